mem_stage_lsu: RTL and testbench

- Parametrised successor to the pipeline's single-cycle memory stage.
- Sits between EX/MEM and MEM/WB. Talks to data memory over a req/gnt/rvalid handshake with variable latency and stalls the pipeline while an access is outstanding.
- Adds byte/half/word (and double when XLEN=64) lane steering, store byte strobes, load sign/zero extension and misalignment detection.
- Produces a registered MEM/WB bundle with a valid bit.

---
 rtl/mem_stage_lsu_if.sv | 56 +++++
 rtl/mem_stage_lsu.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// EX/MEM command, data-memory req/gnt/rvalid and MEM/WB bundle between the pipeline and mem_stage_lsu.
// slave = LSU side, master = pipeline/memory side.
interface mem_stage_lsu_if #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5,
    parameter int STRB_W   = XLEN / 8
);
    logic                in_valid;
    logic [REG_BITS-1:0] in_rd;
    logic                in_write_en;
    logic                in_mem_read;
    logic                in_mem_write;
    logic [1:0]          in_ls_type;
    logic                in_unsigned;
    logic [1:0]          in_wsel;
    logic [XLEN-1:0]     in_alu_out;
    logic [XLEN-1:0]     in_store_data;
    logic [XLEN-1:0]     in_return_pc;
    logic                stall;

    logic                dmem_req;
    logic                dmem_we;
    logic [XLEN-1:0]     dmem_addr;
    logic [XLEN-1:0]     dmem_wdata;
    logic [STRB_W-1:0]   dmem_wstrb;
    logic                dmem_gnt;
    logic                dmem_rvalid;
    logic [XLEN-1:0]     dmem_rdata;

    logic                wb_valid;
    logic                wb_write_en;
    logic [REG_BITS-1:0] wb_rd;
    logic [XLEN-1:0]     wb_alu_out;
    logic [XLEN-1:0]     wb_load_data;
    logic [XLEN-1:0]     wb_return_pc;
    logic [1:0]          wb_wsel;
    logic                wb_misalign;

    modport slave (
        input  in_valid, in_rd, in_write_en, in_mem_read, in_mem_write, in_ls_type,
               in_unsigned, in_wsel, in_alu_out, in_store_data, in_return_pc,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_write_en, wb_rd, wb_alu_out, wb_load_data, wb_return_pc,
               wb_wsel, wb_misalign
    );

    modport master (
        output in_valid, in_rd, in_write_en, in_mem_read, in_mem_write, in_ls_type,
               in_unsigned, in_wsel, in_alu_out, in_store_data, in_return_pc,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_write_en, wb_rd, wb_alu_out, wb_load_data, wb_return_pc,
               wb_wsel, wb_misalign
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage with variable-latency dmem handshake; store 2 / load 3 cycles minimum, stall held while busy.
// ALIGN_TRAP_EN: misaligned ops trap in one cycle instead of being forced to size alignment.
module mem_stage_lsu #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int REG_BITS  = $clog2(REG_COUNT),
    parameter int STRB_W    = XLEN / 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_lsu_if.slave bus
);
    localparam int OFF_W = $clog2(STRB_W);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    typedef struct packed {
        logic                valid;
        logic                write_en;
        logic [REG_BITS-1:0] rd;
        logic [XLEN-1:0]     alu_out;
        logic [XLEN-1:0]     load_data;
        logic [XLEN-1:0]     return_pc;
        logic [1:0]          wsel;
    } wb_t;

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [OFF_W-1:0]  r_lo;
    logic [1:0]        r_size_log2;
    logic              r_unsigned;
    wb_t               r_wb;

    logic              w_mem_op;
    logic [1:0]        w_size_log2;
    logic [OFF_W-1:0]  w_align_mask;
    logic [OFF_W-1:0]  w_addr_lo_raw;
    logic [OFF_W-1:0]  w_lo;
    logic              w_trap;
    logic              w_start;
    logic [STRB_W-1:0] w_strb_base;
    logic [STRB_W-1:0] w_strb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_addr_aligned;
    logic [XLEN-1:0]   w_rshift;
    logic [XLEN-1:0]   w_ext_mask;
    logic              w_sign;
    logic [XLEN-1:0]   w_load_ext;
    logic              w_stall;
    wb_t               w_wb_next;

    assign w_mem_op      = bus.in_mem_read | bus.in_mem_write;
    assign w_addr_lo_raw = bus.in_alu_out[OFF_W-1:0];

    always_comb begin
        w_size_log2 = 2'd2;
        w_strb_base = STRB_W'(8'h0F);
        case (bus.in_ls_type)
            2'b00: begin w_size_log2 = 2'd0; w_strb_base = STRB_W'(8'h01); end
            2'b01: begin w_size_log2 = 2'd1; w_strb_base = STRB_W'(8'h03); end
            2'b10: begin w_size_log2 = 2'd2; w_strb_base = STRB_W'(8'h0F); end
            default: begin
                // Double only exists on the 64-bit datapath; otherwise behave as word.
                if (XLEN == 64) begin
                    w_size_log2 = 2'd3;
                    w_strb_base = STRB_W'(8'hFF);
                end
            end
        endcase
    end

    assign w_align_mask = OFF_W'((4'd1 << w_size_log2) - 4'd1);

`ifdef ALIGN_TRAP_EN
    assign w_trap = (r_state == S_IDLE) & w_mem_op & (|(w_addr_lo_raw & w_align_mask));
    assign w_lo   = w_addr_lo_raw;
`else
    assign w_trap = 1'b0;
    assign w_lo   = w_addr_lo_raw & ~w_align_mask;
`endif

    assign w_start        = bus.in_valid & w_mem_op & ~w_trap;
    assign w_strb         = w_strb_base << w_lo;
    assign w_wdata        = bus.in_store_data << {w_lo, 3'b000};
    assign w_addr_aligned = {bus.in_alu_out[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    // Load lane: shift the addressed bytes down, then mask and extend to the access size.
    assign w_rshift = bus.dmem_rdata >> {r_lo, 3'b000};

    always_comb begin
        w_ext_mask = '1;
        w_sign     = w_rshift[XLEN-1];
        case (r_size_log2)
            2'd0: begin w_ext_mask = XLEN'(8'hFF);         w_sign = w_rshift[7];  end
            2'd1: begin w_ext_mask = XLEN'(16'hFFFF);      w_sign = w_rshift[15]; end
            2'd2: begin w_ext_mask = XLEN'(32'hFFFF_FFFF); w_sign = w_rshift[31]; end
            default: ;
        endcase
        w_load_ext = w_rshift & w_ext_mask;
        if (!r_unsigned && w_sign) begin
            w_load_ext = w_load_ext | ~w_ext_mask;
        end
    end

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = w_start;
            S_REQ:   w_stall = ~(bus.dmem_gnt & r_we);
            S_WAIT:  w_stall = ~bus.dmem_rvalid;
            default: w_stall = 1'b0;
        endcase
    end

    // Pass-through fields always come from EX/MEM, which upstream holds until completion.
    always_comb begin
        w_wb_next           = '0;
        w_wb_next.valid     = 1'b1;
        w_wb_next.write_en  = bus.in_write_en & ~w_trap;
        w_wb_next.rd        = bus.in_rd;
        w_wb_next.alu_out   = bus.in_alu_out;
        w_wb_next.return_pc = bus.in_return_pc;
        w_wb_next.wsel      = bus.in_wsel;
        w_wb_next.load_data = (r_state == S_WAIT) ? w_load_ext : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_lo        <= '0;
            r_size_log2 <= '0;
            r_unsigned  <= 1'b0;
            r_wb        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_REQ;
                        r_req       <= 1'b1;
                        r_we        <= bus.in_mem_write;
                        r_addr      <= w_addr_aligned;
                        r_wdata     <= w_wdata;
                        r_wstrb     <= w_strb;
                        r_lo        <= w_lo;
                        r_size_log2 <= w_size_log2;
                        r_unsigned  <= bus.in_unsigned;
                        r_wb.valid  <= 1'b0;
                    end else if (bus.in_valid) begin
                        r_wb <= w_wb_next;
                    end else begin
                        r_wb.valid <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (bus.dmem_gnt) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_wb    <= w_wb_next;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.dmem_rvalid) begin
                        r_wb    <= w_wb_next;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            r_misalign <= w_trap;
        end else if (r_state != S_IDLE) begin
            r_misalign <= 1'b0;
        end
    end

    assign bus.wb_misalign = r_misalign;
`else
    assign bus.wb_misalign = 1'b0;
`endif

    assign bus.stall        = w_stall;
    assign bus.dmem_req     = r_req;
    assign bus.dmem_we      = r_we;
    assign bus.dmem_addr    = r_addr;
    assign bus.dmem_wdata   = r_wdata;
    assign bus.dmem_wstrb   = r_wstrb;
    assign bus.wb_valid     = r_wb.valid;
    assign bus.wb_write_en  = r_wb.write_en;
    assign bus.wb_rd        = r_wb.rd;
    assign bus.wb_alu_out   = r_wb.alu_out;
    assign bus.wb_load_data = r_wb.load_data;
    assign bus.wb_return_pc = r_wb.return_pc;
    assign bus.wb_wsel      = r_wb.wsel;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level model with a byte-addressed memory.
module tb_mem_stage_lsu;
    localparam int XLEN     = 32;
    localparam int REG_BITS = 5;
    localparam int STRB_W   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_lsu_if #(.XLEN(XLEN), .REG_BITS(REG_BITS), .STRB_W(STRB_W)) bus ();

    mem_stage_lsu #(.XLEN(XLEN), .REG_COUNT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic drive_idle();
        bus.in_valid      = 1'b0;
        bus.in_rd         = '0;
        bus.in_write_en   = 1'b0;
        bus.in_mem_read   = 1'b0;
        bus.in_mem_write  = 1'b0;
        bus.in_ls_type    = 2'b00;
        bus.in_unsigned   = 1'b0;
        bus.in_wsel       = 2'b00;
        bus.in_alu_out    = '0;
        bus.in_store_data = '0;
        bus.in_return_pc  = '0;
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store. Called just after a rising edge.
    task automatic run_op(input int kind, input logic [1:0] lst, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input int gd, input int rd_dly);
        int size, lo, cycles, stall_cnt, req_cnt, rv_left;
        logic trap, is_mem, granted, done, we_in;
        logic [31:0] eff, exp_addr, exp_wdata, rword, expv, mask, rpc, w;
        logic [3:0] exp_strb;
        logic [4:0] rdi;
        logic [1:0] ws;

        size = (lst == 2'd0) ? 1 : (lst == 2'd1) ? 2 : 4;
`ifdef ALIGN_TRAP_EN
        trap = (kind != 0) && ((addr % size) != 0);
        eff  = addr;
`else
        trap = 1'b0;
        eff  = addr - (addr % size);
`endif
        is_mem    = (kind != 0) && !trap;
        lo        = int'(eff % 4);
        exp_addr  = eff - lo;
        exp_wdata = sdata << (8 * lo);
        exp_strb  = 4'(((1 << size) - 1) << lo);
        rdi   = 5'($urandom);
        ws    = 2'($urandom);
        rpc   = $urandom;
        we_in = 1'($urandom);
        rword = '0;

        bus.in_valid      = 1'b1;
        bus.in_rd         = rdi;
        bus.in_write_en   = we_in;
        bus.in_mem_read   = (kind == 1);
        bus.in_mem_write  = (kind == 2);
        bus.in_ls_type    = lst;
        bus.in_unsigned   = uns;
        bus.in_wsel       = ws;
        bus.in_alu_out    = addr;
        bus.in_store_data = sdata;
        bus.in_return_pc  = rpc;

        cycles = 0; stall_cnt = 0; req_cnt = 0; rv_left = 0;
        granted = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (cycles > 0) check_eq("wb_valid_busy", bus.wb_valid, 0);
            bus.dmem_gnt    = 1'b0;
            bus.dmem_rvalid = 1'b0;
            bus.dmem_rdata  = $urandom;
            if (bus.dmem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    check_eq("dmem_addr", bus.dmem_addr, exp_addr);
                    check_eq("dmem_we", bus.dmem_we, kind == 2);
                    check_eq("dmem_wstrb", bus.dmem_wstrb, exp_strb);
                    if (kind == 2) check_eq("dmem_wdata", bus.dmem_wdata, exp_wdata);
                end
                if (req_cnt > gd) begin
                    bus.dmem_gnt = 1'b1;
                    granted = 1'b1;
                    rv_left = rd_dly;
                    if (kind == 2) begin
                        for (int b = 0; b < 4; b++) begin
                            if (exp_strb[b]) begin
                                w = rd_mem(exp_addr);
                                w[8*b +: 8] = exp_wdata[8*b +: 8];
                                mem[exp_addr] = w;
                            end
                        end
                    end
                end
            end else if (granted && kind == 1) begin
                if (rv_left == 0) begin
                    rword = rd_mem(exp_addr);
                    bus.dmem_rvalid = 1'b1;
                    bus.dmem_rdata  = rword;
                end else begin
                    rv_left--;
                end
            end
            #1;
            if (bus.stall) stall_cnt++;
            else done = 1'b1;
            cycles++;
            if (cycles > 60 && !done) begin
                n_checks++;
                n_fail++;
                $display("FAIL op_timeout: still stalled after %0d cycles, limit 60", cycles);
                done = 1'b1;
            end
        end

        check_eq("stall_cycles", stall_cnt,
                 !is_mem ? 0 : (kind == 2) ? 1 + gd : 2 + gd + rd_dly);
        check_eq("req_cycles", req_cnt, is_mem ? gd + 1 : 0);

        @(posedge clk);
        #1;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;

        expv = '0;
        if (kind == 1 && !trap) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
            expv = (rword >> (8 * lo)) & mask;
            if (!uns && size < 4 && expv[8*size-1]) expv = expv | ~mask;
        end
        check_eq("wb_valid", bus.wb_valid, 1);
        check_eq("wb_rd", bus.wb_rd, rdi);
        check_eq("wb_alu_out", bus.wb_alu_out, addr);
        check_eq("wb_return_pc", bus.wb_return_pc, rpc);
        check_eq("wb_wsel", bus.wb_wsel, ws);
        check_eq("wb_write_en", bus.wb_write_en, we_in && !trap);
        check_eq("wb_misalign", bus.wb_misalign, trap);
        check_eq("wb_load_data", bus.wb_load_data, expv);
    endtask

    task automatic idle_cycle();
        drive_idle();
        @(negedge clk);
        check_eq("idle_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        check_eq("idle_wb_valid", bus.wb_valid, 0);
    endtask

    initial begin
        int kind;
        logic [31:0] a;

        drive_idle();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_wb_valid", bus.wb_valid, 0);
        check_eq("rst_dmem_req", bus.dmem_req, 0);
        check_eq("rst_dmem_addr", bus.dmem_addr, 0);
        check_eq("rst_dmem_wstrb", bus.dmem_wstrb, 0);
        check_eq("rst_stall", bus.stall, 0);
        check_eq("rst_wb_load", bus.wb_load_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // SB 0xA5 to 0x103, immediate grant
        run_op(2, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 0, 0);
        check_eq("sb_mem", mem[32'h100][31:24], 8'hA5);
        // LB / LBU / LH from 0x102
        mem[32'h100] = 32'h1280_FF00;
        run_op(1, 2'b00, 1'b0, 32'h102, 0, 0, 3);
        run_op(1, 2'b00, 1'b1, 32'h102, 0, 0, 3);
        mem[32'h100] = 32'h8001_1234;
        run_op(1, 2'b01, 1'b0, 32'h102, 0, 1, 0);
        // LW with delayed grant
        mem[32'h104] = 32'hDEAD_BEEF;
        run_op(1, 2'b10, 1'b0, 32'h104, 0, 3, 0);
        // ADD, SW, ADD back to back
        run_op(0, 2'b10, 1'b0, 32'h0000_1234, 0, 0, 0);
        run_op(2, 2'b10, 1'b0, 32'h108, 32'hCAFE_F00D, 0, 0);
        run_op(0, 2'b10, 1'b0, 32'h0000_5678, 0, 0, 0);
        check_eq("sw_mem", mem[32'h108], 32'hCAFE_F00D);
        // Misaligned word load
        run_op(1, 2'b10, 1'b0, 32'h102, 0, 0, 0);
        idle_cycle();

        // Reset while a load waits for rvalid
        bus.in_valid = 1'b1; bus.in_mem_read = 1'b1; bus.in_ls_type = 2'b10;
        bus.in_alu_out = 32'h40; bus.in_write_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        bus.dmem_gnt = bus.dmem_req;
        @(posedge clk); #1;
        bus.dmem_gnt = 1'b0;
        @(negedge clk);
        check_eq("wait_stall", bus.stall, 1);
        drive_idle();
        rst = 1'b1;
        #1;
        check_eq("async_req_drop", bus.dmem_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_stall", bus.stall, 0);
        check_eq("post_rst_req", bus.dmem_req, 0);
        check_eq("post_rst_wb_valid", bus.wb_valid, 0);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1111_2222;
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b0;
        check_eq("late_rvalid_wb", bus.wb_valid, 0);

        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 2));
            a = 32'h100 + $urandom_range(0, 63);
            run_op(kind, 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
